// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM bank controller.
// Holds the FSM state encoding, the read-latency limits and the byte width.
package sram_pkg;

   typedef enum logic {
      ST_INIT = 1'b0,
      ST_RUN  = 1'b1
   } state_e;

   localparam int RD_LAT_MIN = 1;
   localparam int RD_LAT_MAX = 4;
   localparam int BYTE_W     = 8;

endpackage

// File: rtl/sram_rd_pipe.sv
// Read-latency shift register for the SRAM bank controller.
// Carries valid/data/err through RD_LAT register stages.
module sram_rd_pipe
   import sram_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              i_valid,
   input  logic [DATA_W-1:0] i_data,
   input  logic              i_err,
   output logic              o_valid,
   output logic [DATA_W-1:0] o_data,
   output logic              o_err
);

   if (RD_LAT < RD_LAT_MIN || RD_LAT > RD_LAT_MAX) begin : g_lat_check
      $error("sram_rd_pipe: RD_LAT out of range");
   end

   logic [RD_LAT-1:0] r_valid;
   logic [RD_LAT-1:0] r_err;
   logic [DATA_W-1:0] r_data [RD_LAT];

   // NOTE: every stage, data included, resets asynchronously so the outputs
   // drop to zero the moment rst_n falls and no in-flight read survives it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_err   <= '0;
         for (int s = 0; s < RD_LAT; s++) begin
            r_data[s] <= '0;
         end
      end else begin
         r_valid[0] <= i_valid;
         r_err[0]   <= i_err;
         r_data[0]  <= i_data;
         for (int s = 1; s < RD_LAT; s++) begin
            r_valid[s] <= r_valid[s-1];
            r_err[s]   <= r_err[s-1];
            r_data[s]  <= r_data[s-1];
         end
      end
   end

   assign o_valid = r_valid[RD_LAT-1];
   assign o_err   = r_err[RD_LAT-1];
   assign o_data  = r_data[RD_LAT-1];

endmodule

// File: rtl/sram_bank_ctrl.sv
// Single-bank SRAM controller: clears the array after reset, then serves
// byte-masked writes and fixed-latency reads with range checking.
module sram_bank_ctrl
   import sram_pkg::*;
#(
   parameter int DATA_W      = 8,
   parameter int DEPTH       = 1024,
   parameter int ADDR_W      = 10,
   parameter int RD_LAT      = 1,
   parameter int COLLIDE_NEW = 0
) (
   input  logic                     clk,
   input  logic                     rst_n,
   output logic                     init_done,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   input  logic [ADDR_W-1:0]        wr_addr,
   input  logic [DATA_W-1:0]        wr_data,
   input  logic [DATA_W/BYTE_W-1:0] wr_be,
   input  logic                     rd_valid,
   output logic                     rd_ready,
   input  logic [ADDR_W-1:0]        rd_addr,
   output logic                     rsp_valid,
   output logic [DATA_W-1:0]        rsp_data,
   output logic                     rsp_err
);

   localparam int                BE_W      = DATA_W / BYTE_W;
   localparam logic [ADDR_W:0]   DEPTH_L   = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

   if (DATA_W % BYTE_W != 0) begin : g_width_check
      $error("sram_bank_ctrl: DATA_W must be a multiple of 8");
   end

   state_e            r_state;
   logic [ADDR_W-1:0] r_init_addr;
   logic              r_init_done;
   logic              r_ready;
   logic [DATA_W-1:0] r_mem [DEPTH];

   logic              w_wr_en;
   logic              w_rd_acc;
   logic              w_rd_in;
   logic [DATA_W-1:0] w_rd_word;
   logic              w_rd_err;

   assign w_wr_en  = wr_valid & r_ready & ({1'b0, wr_addr} < DEPTH_L);
   assign w_rd_acc = rd_valid & r_ready;
   assign w_rd_in  = {1'b0, rd_addr} < DEPTH_L;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_INIT;
         r_init_addr <= '0;
         r_init_done <= 1'b0;
         r_ready     <= 1'b0;
      end else begin
         case (r_state)
            ST_INIT: begin
               if (r_init_addr == LAST_ADDR) begin
                  r_state     <= ST_RUN;
                  r_init_done <= 1'b1;
                  r_ready     <= 1'b1;
               end else begin
                  r_init_addr <= r_init_addr + ADDR_W'(1);
               end
            end
            ST_RUN:  r_state <= ST_RUN;
            default: r_state <= ST_INIT;
         endcase
      end
   end

   // NOTE: the array has no reset; the INIT sweep clears it word by word,
   // which keeps it mappable onto plain storage.
   always_ff @(posedge clk) begin
      if (r_state == ST_INIT) begin
         r_mem[r_init_addr] <= '0;
      end else if (w_wr_en) begin
         for (int b = 0; b < BE_W; b++) begin
            if (wr_be[b]) begin
               r_mem[wr_addr][b*BYTE_W +: BYTE_W] <= wr_data[b*BYTE_W +: BYTE_W];
            end
         end
      end
   end

   // Read word captured at acceptance; optionally merges a same-address write.
   always_comb begin
      w_rd_word = '0;
      w_rd_err  = 1'b0;
      if (w_rd_acc) begin
         if (w_rd_in) begin
            w_rd_word = r_mem[rd_addr];
            if (COLLIDE_NEW != 0 && w_wr_en && wr_addr == rd_addr) begin
               for (int b = 0; b < BE_W; b++) begin
                  if (wr_be[b]) begin
                     w_rd_word[b*BYTE_W +: BYTE_W] = wr_data[b*BYTE_W +: BYTE_W];
                  end
               end
            end
         end else begin
            w_rd_err = 1'b1;
         end
      end
   end

   sram_rd_pipe #(
      .DATA_W (DATA_W),
      .RD_LAT (RD_LAT)
   ) u_rd_pipe (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_valid (w_rd_acc),
      .i_data  (w_rd_word),
      .i_err   (w_rd_err),
      .o_valid (rsp_valid),
      .o_data  (rsp_data),
      .o_err   (rsp_err)
   );

   assign init_done = r_init_done;
   assign wr_ready  = r_ready;
   assign rd_ready  = r_ready;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Bench for sram_bank_ctrl: two instances (RD_LAT=3/old-on-collide/DEPTH=1000 and
// RD_LAT=4/new-on-collide/DEPTH=1024) share stimulus and are scored against a word-array model.
module tb_sram_bank_ctrl;

   localparam int DW    = 32;
   localparam int AW    = 10;
   localparam int BW    = DW / 8;
   localparam int DEP_A = 1000;
   localparam int DEP_B = 1024;
   localparam int LAT_A = 3;
   localparam int LAT_B = 4;

   logic          clk      = 1'b0;
   logic          rst_n    = 1'b0;
   logic          wr_valid = 1'b0;
   logic          rd_valid = 1'b0;
   logic [AW-1:0] wr_addr  = '0;
   logic [AW-1:0] rd_addr  = '0;
   logic [DW-1:0] wr_data  = '0;
   logic [BW-1:0] wr_be    = '0;

   logic          a_init_done, a_wr_ready, a_rd_ready, a_rsp_valid, a_rsp_err;
   logic [DW-1:0] a_rsp_data;
   logic          b_init_done, b_wr_ready, b_rd_ready, b_rsp_valid, b_rsp_err;
   logic [DW-1:0] b_rsp_data;

   always #5 clk = ~clk;

   sram_bank_ctrl #(
      .DATA_W(DW), .DEPTH(DEP_A), .ADDR_W(AW), .RD_LAT(LAT_A), .COLLIDE_NEW(0)
   ) u_dut_a (
      .clk(clk), .rst_n(rst_n), .init_done(a_init_done),
      .wr_valid(wr_valid), .wr_ready(a_wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be),
      .rd_valid(rd_valid), .rd_ready(a_rd_ready), .rd_addr(rd_addr),
      .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
   );

   sram_bank_ctrl #(
      .DATA_W(DW), .DEPTH(DEP_B), .ADDR_W(AW), .RD_LAT(LAT_B), .COLLIDE_NEW(1)
   ) u_dut_b (
      .clk(clk), .rst_n(rst_n), .init_done(b_init_done),
      .wr_valid(wr_valid), .wr_ready(b_wr_ready), .wr_addr(wr_addr),
      .wr_data(wr_data), .wr_be(wr_be),
      .rd_valid(rd_valid), .rd_ready(b_rd_ready), .rd_addr(rd_addr),
      .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
   );

   // Reference model: word arrays, cycles since reset release, response queues.
   typedef struct {
      int            due;
      logic [DW-1:0] data;
      logic          err;
   } rsp_t;

   rsp_t          q_a[$];
   rsp_t          q_b[$];
   logic [DW-1:0] mem_a [DEP_B];
   logic [DW-1:0] mem_b [DEP_B];
   int            edges = 0;
   int            rel   = 0;
   int            total = 0;
   int            bad   = 0;
   logic          ea_v, ea_e, eb_v, eb_e;
   logic [DW-1:0] ea_d, eb_d;

   function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                           input logic [DW-1:0] new_w,
                                           input logic [BW-1:0] be);
      logic [DW-1:0] res;
      res = old_w;
      for (int i = 0; i < BW; i++) begin
         if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
      end
      return res;
   endfunction

   task automatic model_clear();
      q_a.delete();
      q_b.delete();
      for (int i = 0; i < DEP_B; i++) begin
         mem_a[i] = '0;
         mem_b[i] = '0;
      end
      rel = 0;
   endtask

   task automatic idle();
      wr_valid = 1'b0;
      rd_valid = 1'b0;
   endtask

   // Advances one clock, applies the model to the inputs seen at that edge,
   // and leaves the expected response for the cycle after it in ea_*/eb_*.
   task automatic clock_cycle();
      rsp_t r;
      @(posedge clk);
      edges++;
      if (rst_n) begin
         if (rel >= DEP_A) begin
            if (rd_valid) begin
               r.due  = edges + LAT_A - 1;
               r.err  = (rd_addr >= DEP_A);
               r.data = r.err ? '0 : mem_a[rd_addr];
               q_a.push_back(r);
            end
            if (wr_valid && wr_addr < DEP_A) mem_a[wr_addr] = merge(mem_a[wr_addr], wr_data, wr_be);
         end
         if (rel >= DEP_B) begin
            if (rd_valid) begin
               r.due  = edges + LAT_B - 1;
               r.err  = 1'b0;
               r.data = mem_b[rd_addr];
               if (wr_valid && wr_addr == rd_addr) r.data = merge(r.data, wr_data, wr_be);
               q_b.push_back(r);
            end
            if (wr_valid) mem_b[wr_addr] = merge(mem_b[wr_addr], wr_data, wr_be);
         end
         rel++;
      end
      #1;
      ea_v = 1'b0; ea_d = '0; ea_e = 1'b0;
      eb_v = 1'b0; eb_d = '0; eb_e = 1'b0;
      if (q_a.size() > 0 && q_a[0].due == edges) begin
         ea_v = 1'b1; ea_d = q_a[0].data; ea_e = q_a[0].err;
         void'(q_a.pop_front());
      end
      if (q_b.size() > 0 && q_b[0].due == edges) begin
         eb_v = 1'b1; eb_d = q_b[0].data; eb_e = q_b[0].err;
         void'(q_b.pop_front());
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      #1;
      total++;
      if ({a_init_done, a_wr_ready, a_rd_ready, a_rsp_valid, a_rsp_data, a_rsp_err} !== '0) begin
         bad++;
         $display("FAIL reset_a: got done=%b rdy=%b/%b v=%b d=%h e=%b, want all 0",
                  a_init_done, a_wr_ready, a_rd_ready, a_rsp_valid, a_rsp_data, a_rsp_err);
      end
      total++;
      if ({b_init_done, b_wr_ready, b_rd_ready, b_rsp_valid, b_rsp_data, b_rsp_err} !== '0) begin
         bad++;
         $display("FAIL reset_b: got done=%b rdy=%b/%b v=%b d=%h e=%b, want all 0",
                  b_init_done, b_wr_ready, b_rd_ready, b_rsp_valid, b_rsp_data, b_rsp_err);
      end
      model_clear();
      idle();
      for (int i = 0; i < 2; i++) begin
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || b_rsp_valid !== eb_v) begin
            bad++;
            $display("FAIL reset_hold: got va=%b vb=%b, want 0 0", a_rsp_valid, b_rsp_valid);
         end
      end
      rst_n = 1'b1;
   endtask

   // Random requests are driven while clearing; they must be ignored.
   task automatic test_init();
      for (int i = 0; i < DEP_B + 2; i++) begin
         if (rel < DEP_A - 4) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, DEP_B - 1));
            wr_data  = $urandom;
            wr_be    = BW'($urandom);
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr  = AW'($urandom_range(0, DEP_B - 1));
         end else begin
            idle();
         end
         clock_cycle();
         total++;
         if ({a_init_done, a_wr_ready, a_rd_ready} !== {3{rel >= DEP_A}}) begin
            bad++;
            $display("FAIL init_a @rel=%0d: got done/rdy=%b%b%b, want %b",
                     rel, a_init_done, a_wr_ready, a_rd_ready, rel >= DEP_A);
         end
         total++;
         if ({b_init_done, b_wr_ready, b_rd_ready} !== {3{rel >= DEP_B}}) begin
            bad++;
            $display("FAIL init_b @rel=%0d: got done/rdy=%b%b%b, want %b",
                     rel, b_init_done, b_wr_ready, b_rd_ready, rel >= DEP_B);
         end
         total++;
         if (a_rsp_valid !== ea_v || b_rsp_valid !== eb_v) begin
            bad++;
            $display("FAIL init_rsp @rel=%0d: got va=%b vb=%b, want %b %b",
                     rel, a_rsp_valid, b_rsp_valid, ea_v, eb_v);
         end
      end
   endtask

   task automatic test_zero_after_init(input string tag, input int fixed_addr);
      int seen_a;
      int bad_a;
      seen_a = 0;
      bad_a  = 0;
      for (int i = 0; i < 8 + LAT_B; i++) begin
         wr_valid = 1'b0;
         rd_valid = (i < 8);
         rd_addr  = (i == 0 && fixed_addr >= 0) ? AW'(fixed_addr) : AW'($urandom_range(0, DEP_A - 1));
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || a_rsp_err !== ea_e) begin
            bad++;
            $display("FAIL %s rsp_a @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     tag, edges, a_rsp_valid, a_rsp_data, a_rsp_err, ea_v, ea_d, ea_e);
         end
         total++;
         if (b_rsp_valid !== eb_v || b_rsp_data !== eb_d || b_rsp_err !== eb_e) begin
            bad++;
            $display("FAIL %s rsp_b @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     tag, edges, b_rsp_valid, b_rsp_data, b_rsp_err, eb_v, eb_d, eb_e);
         end
         if (a_rsp_valid === 1'b1) begin
            seen_a++;
            if (a_rsp_data !== '0) bad_a++;
         end
      end
      total++;
      if (seen_a != 8 || bad_a != 0) begin
         bad++;
         $display("FAIL %s zero_count: got %0d responses (%0d nonzero), want 8 (0 nonzero)",
                  tag, seen_a, bad_a);
      end
   endtask

   task automatic test_byte_enable();
      logic [DW-1:0] got_a, got_b;
      got_a = 'x;
      got_b = 'x;
      for (int i = 0; i < 3 + LAT_B; i++) begin
         idle();
         case (i)
            0: begin wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 32'hAABBCCDD; wr_be = 4'hF; end
            1: begin wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 32'h11223344; wr_be = 4'h5; end
            2: begin rd_valid = 1'b1; rd_addr = AW'(5); end
            default: ;
         endcase
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || a_rsp_err !== ea_e) begin
            bad++;
            $display("FAIL byte_en rsp_a @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, a_rsp_valid, a_rsp_data, a_rsp_err, ea_v, ea_d, ea_e);
         end
         total++;
         if (b_rsp_valid !== eb_v || b_rsp_data !== eb_d || b_rsp_err !== eb_e) begin
            bad++;
            $display("FAIL byte_en rsp_b @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, b_rsp_valid, b_rsp_data, b_rsp_err, eb_v, eb_d, eb_e);
         end
         if (a_rsp_valid === 1'b1) got_a = a_rsp_data;
         if (b_rsp_valid === 1'b1) got_b = b_rsp_data;
      end
      total++;
      if (got_a !== 32'hAA22CC44 || got_b !== 32'hAA22CC44) begin
         bad++;
         $display("FAIL byte_en_word: got a=%h b=%h, want aa22cc44", got_a, got_b);
      end
   endtask

   task automatic test_back_to_back();
      int            first_a, first_b;
      logic [DW-1:0] seq_a[$];
      logic [DW-1:0] seq_b[$];
      first_a = -1;
      first_b = -1;
      for (int i = 0; i < 6 + LAT_B; i++) begin
         idle();
         if (i < 3) begin
            wr_valid = 1'b1; wr_addr = AW'(i + 1); wr_data = 32'hC0DE0000 + DW'(i + 1); wr_be = 4'hF;
         end else if (i < 6) begin
            rd_valid = 1'b1; rd_addr = AW'(i - 2);
         end
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || a_rsp_err !== ea_e) begin
            bad++;
            $display("FAIL b2b rsp_a @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, a_rsp_valid, a_rsp_data, a_rsp_err, ea_v, ea_d, ea_e);
         end
         total++;
         if (b_rsp_valid !== eb_v || b_rsp_data !== eb_d || b_rsp_err !== eb_e) begin
            bad++;
            $display("FAIL b2b rsp_b @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, b_rsp_valid, b_rsp_data, b_rsp_err, eb_v, eb_d, eb_e);
         end
         if (a_rsp_valid === 1'b1) begin
            if (first_a < 0) first_a = i;
            seq_a.push_back(a_rsp_data);
         end
         if (b_rsp_valid === 1'b1) begin
            if (first_b < 0) first_b = i;
            seq_b.push_back(b_rsp_data);
         end
      end
      // First read is accepted at the edge of step 3 and becomes visible RD_LAT-1 steps later.
      total++;
      if (first_a != 3 + LAT_A - 1 || first_b != 3 + LAT_B - 1) begin
         bad++;
         $display("FAIL b2b_timing: got first a=%0d b=%0d, want %0d %0d",
                  first_a, first_b, 3 + LAT_A - 1, 3 + LAT_B - 1);
      end
      total++;
      if (seq_a.size() != 3 || seq_b.size() != 3 ||
          seq_a[0] !== 32'hC0DE0001 || seq_a[1] !== 32'hC0DE0002 || seq_a[2] !== 32'hC0DE0003 ||
          seq_b[0] !== 32'hC0DE0001 || seq_b[1] !== 32'hC0DE0002 || seq_b[2] !== 32'hC0DE0003) begin
         bad++;
         $display("FAIL b2b_order: got %0d/%0d responses, want 3/3 in order c0de0001..3",
                  seq_a.size(), seq_b.size());
      end
   endtask

   task automatic test_collision();
      logic [DW-1:0] got_a, got_b;
      got_a = 'x;
      got_b = 'x;
      for (int i = 0; i < 1 + LAT_B; i++) begin
         idle();
         if (i == 0) begin
            wr_valid = 1'b1; wr_addr = AW'(7); wr_data = 32'h5A; wr_be = 4'hF;
            rd_valid = 1'b1; rd_addr = AW'(7);
         end
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || a_rsp_err !== ea_e) begin
            bad++;
            $display("FAIL collide rsp_a @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, a_rsp_valid, a_rsp_data, a_rsp_err, ea_v, ea_d, ea_e);
         end
         total++;
         if (b_rsp_valid !== eb_v || b_rsp_data !== eb_d || b_rsp_err !== eb_e) begin
            bad++;
            $display("FAIL collide rsp_b @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, b_rsp_valid, b_rsp_data, b_rsp_err, eb_v, eb_d, eb_e);
         end
         if (a_rsp_valid === 1'b1) got_a = a_rsp_data;
         if (b_rsp_valid === 1'b1) got_b = b_rsp_data;
      end
      total++;
      if (got_a !== 32'h0 || got_b !== 32'h5A) begin
         bad++;
         $display("FAIL collide_word: got old-mode=%h new-mode=%h, want 00000000 0000005a", got_a, got_b);
      end
   endtask

   task automatic test_range();
      logic [DW-1:0] d_a[$];
      logic          e_a[$];
      logic [DW-1:0] d_b[$];
      for (int i = 0; i < 3 + LAT_B; i++) begin
         idle();
         case (i)
            0: begin wr_valid = 1'b1; wr_addr = AW'(DEP_A); wr_data = 32'hDEADBEEF; wr_be = 4'hF; end
            1: begin rd_valid = 1'b1; rd_addr = AW'(DEP_A); end
            2: begin rd_valid = 1'b1; rd_addr = AW'(DEP_A - 1); end
            default: ;
         endcase
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || a_rsp_err !== ea_e) begin
            bad++;
            $display("FAIL range rsp_a @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, a_rsp_valid, a_rsp_data, a_rsp_err, ea_v, ea_d, ea_e);
         end
         total++;
         if (b_rsp_valid !== eb_v || b_rsp_data !== eb_d || b_rsp_err !== eb_e) begin
            bad++;
            $display("FAIL range rsp_b @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, b_rsp_valid, b_rsp_data, b_rsp_err, eb_v, eb_d, eb_e);
         end
         if (a_rsp_valid === 1'b1) begin d_a.push_back(a_rsp_data); e_a.push_back(a_rsp_err); end
         if (b_rsp_valid === 1'b1) d_b.push_back(b_rsp_data);
      end
      total++;
      if (d_a.size() != 2 || d_a[0] !== '0 || e_a[0] !== 1'b1 || e_a[1] !== 1'b0) begin
         bad++;
         $display("FAIL range_a: got %0d responses, first d=%h e=%b, want 2, d=0 e=1 then e=0",
                  d_a.size(), (d_a.size() > 0) ? d_a[0] : 'x, (e_a.size() > 0) ? e_a[0] : 1'bx);
      end
      total++;
      if (d_b.size() != 2 || d_b[0] !== 32'hDEADBEEF) begin
         bad++;
         $display("FAIL range_b: got %0d responses, first d=%h, want 2, deadbeef",
                  d_b.size(), (d_b.size() > 0) ? d_b[0] : 'x);
      end
   endtask

   // Addresses cluster near 0 and the top boundary to provoke collisions and range hits.
   task automatic test_random();
      for (int i = 0; i < 400 + LAT_B; i++) begin
         idle();
         if (i < 400) begin
            wr_valid = 1'($urandom_range(0, 1));
            wr_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(992, DEP_B - 1));
            wr_data  = $urandom;
            wr_be    = BW'($urandom);
            rd_valid = 1'($urandom_range(0, 1));
            rd_addr  = ($urandom_range(0, 1) != 0) ? AW'($urandom_range(0, 15)) : AW'($urandom_range(992, DEP_B - 1));
         end
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || a_rsp_err !== ea_e) begin
            bad++;
            $display("FAIL random rsp_a @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, a_rsp_valid, a_rsp_data, a_rsp_err, ea_v, ea_d, ea_e);
         end
         total++;
         if (b_rsp_valid !== eb_v || b_rsp_data !== eb_d || b_rsp_err !== eb_e) begin
            bad++;
            $display("FAIL random rsp_b @%0d: got v=%b d=%h e=%b, want v=%b d=%h e=%b",
                     edges, b_rsp_valid, b_rsp_data, b_rsp_err, eb_v, eb_d, eb_e);
         end
      end
   endtask

   // Reset lands two cycles after a read is accepted, while it is still in flight.
   task automatic test_reset_inflight();
      for (int i = 0; i < 4; i++) begin
         idle();
         if (i == 0) begin wr_valid = 1'b1; wr_addr = AW'(5); wr_data = 32'h12345678; wr_be = 4'hF; end
         if (i == 1) begin rd_valid = 1'b1; rd_addr = AW'(5); end
         clock_cycle();
         total++;
         if (a_rsp_valid !== ea_v || a_rsp_data !== ea_d || b_rsp_valid !== eb_v || b_rsp_data !== eb_d) begin
            bad++;
            $display("FAIL inflight rsp @%0d: got va=%b da=%h vb=%b db=%h, want %b %h %b %h",
                     edges, a_rsp_valid, a_rsp_data, b_rsp_valid, b_rsp_data, ea_v, ea_d, eb_v, eb_d);
         end
      end
      test_reset();
   endtask

   initial begin
      test_reset();
      test_init();
      test_zero_after_init("zero", -1);
      test_byte_enable();
      test_back_to_back();
      test_collision();
      test_range();
      test_random();
      test_reset_inflight();
      test_init();
      test_zero_after_init("cleared", 5);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sram_bank_ctrl.md
SRAM_BANK_CTRL -- requirements
Module: sram_bank_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_W, default 8, data word width; SHALL be a multiple of 8.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of words; SHALL be 2..65536 and need not be a power of 2.
REQ-003 The block SHALL have parameter ADDR_W, default 10, address width; SHALL satisfy 2**ADDR_W >= DEPTH.
REQ-004 The block SHALL have parameter RD_LAT, default 1, read latency in cycles; SHALL be 1..4.
REQ-005 The block SHALL have parameter COLLIDE_NEW, default 0; 0 means a same-cycle same-address read returns old data, 1 means it returns new data.
REQ-006 The block SHALL derive BE_W = DATA_W/8.
REQ-007 clk  in  1  sole clock, all state on rising edge.
REQ-008 rst_n  in  1  reset, asynchronous, active-low.
REQ-009 init_done  out  1  high once the memory clear has finished.
REQ-010 wr_valid  in  1  write request.
REQ-011 wr_ready  out  1  write accepted when wr_valid and wr_ready are both high.
REQ-012 wr_addr  in  ADDR_W  write word address.
REQ-013 wr_data  in  DATA_W  write data.
REQ-014 wr_be  in  BE_W  byte enables; bit i covers byte i.
REQ-015 rd_valid  in  1  read request.
REQ-016 rd_ready  out  1  read accepted when rd_valid and rd_ready are both high.
REQ-017 rd_addr  in  ADDR_W  read word address.
REQ-018 rsp_valid  out  1  read response strobe, one cycle per accepted read.
REQ-019 rsp_data  out  DATA_W  read data, qualified by rsp_valid.
REQ-020 rsp_err  out  1  out-of-range read, qualified by rsp_valid.

Function
REQ-021 The block SHALL have FSM states INIT and RUN; it SHALL enter INIT on reset and go INIT->RUN after the last clear write; RUN SHALL persist until reset.
REQ-022 In INIT, the block SHALL write zero to word k in the k-th cycle after reset release, k = 0..DEPTH-1, and init_done SHALL rise in the cycle after word DEPTH-1 is written.
REQ-023 In INIT, wr_ready and rd_ready SHALL be 0 and requests SHALL be ignored; in RUN, wr_ready = rd_ready = 1. There is no backpressure in RUN.
REQ-024 An accepted write SHALL update only the bytes whose wr_be bit is 1; wr_be of all zeros SHALL leave memory unchanged.
REQ-025 A write with wr_addr >= DEPTH SHALL be dropped silently.
REQ-026 For a read accepted in cycle N, rsp_valid SHALL be high for exactly one cycle, cycle N+RD_LAT, with no gaps or reordering.
REQ-027 Back-to-back reads SHALL be accepted every cycle, giving back-to-back responses.
REQ-028 Read data SHALL be sampled from the array in the acceptance cycle; writes after acceptance SHALL NOT affect that response.
REQ-029 For a read with rd_addr >= DEPTH, the block SHALL return rsp_data = 0 and rsp_err = 1; otherwise rsp_err = 0.
REQ-030 For a read and write accepted in the same cycle at the same address, the response SHALL be the pre-write word if COLLIDE_NEW = 0, or the byte-merged post-write word if COLLIDE_NEW = 1.
REQ-031 When rsp_valid = 0, rsp_data and rsp_err SHALL be 0.
REQ-032 The block SHALL NOT drive any tri-state or inout port.

Reset
REQ-033 Assertion of rst_n low SHALL immediately force init_done = 0, wr_ready = 0, rd_ready = 0, rsp_valid = 0, rsp_data = 0, rsp_err = 0, and the FSM to INIT.
REQ-034 Reset mid-operation SHALL discard all in-flight reads, and no response SHALL appear for them after reset release.
REQ-035 After every reset release the block SHALL re-run the full INIT clear, so prior contents are lost.

Structure
REQ-036 Package sram_pkg SHALL hold the FSM state enum, the RD_LAT limits (1, 4) and the byte width constant 8.
REQ-037 The read-latency shift register, carrying valid/data/err for RD_LAT stages, SHALL be sub-module sram_rd_pipe.
REQ-038 The array SHALL be a flat register array of DEPTH words, with no vendor macros.

Verification
REQ-039 Reset, then idle with DEPTH = 1024: init_done rises 1024 cycles after release; a read of any address then returns 0.
REQ-040 With DATA_W = 32: write addr 5 data 0xAABBCCDD be 0xF, then write addr 5 data 0x11223344 be 0x5; a read of addr 5 returns 0xAA22CC44.
REQ-041 With RD_LAT = 3: reads to addr 1, 2, 3 on consecutive cycles return responses in cycles N+3, N+4, N+5, in order.
REQ-042 Same-cycle write addr 7 of 0x5A (old value 0x00) and read addr 7 return 0x00 with COLLIDE_NEW = 0, and 0x5A with COLLIDE_NEW = 1.
REQ-043 With DEPTH = 1000: a write to addr 1000 is dropped; a read of addr 1000 returns rsp_err = 1, rsp_data = 0; a read of addr 999 returns rsp_err = 0.
REQ-044 With RD_LAT = 4: pulse rst_n low 2 cycles after a read is accepted; no rsp_valid follows, INIT re-runs, and previously written data reads back as 0.
